// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   tx_state_t  - transmitter FSM state encoding
//   START_BIT   - line level of the start bit
//   STOP_BIT    - line level of the stop bit (also the idle level)
//   DATA_BITS   - data bits per frame
//   timer_width - bits needed for a bit timer counting 0..clks-1
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;
    localparam int unsigned DATA_BITS = 8;

    // Smallest width (at least 1) whose range covers 0..clks-1.
    function automatic int unsigned timer_width(input int unsigned clks);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < clks) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/tx_data_buff.sv
// tx_data_buff: single-entry holding buffer in front of the UART transmitter.
//   clk         - system clock
//   n_rst       - asynchronous active-low reset
//   tx_data     - byte offered by the host
//   data_write  - write strobe; accepted only while the buffer is empty
//   consume     - FSM takes the buffered byte on this edge
//   buf_data    - buffered byte
//   buffer_full - buffer occupied
//   write_error - one-cycle pulse after a write arrives while full
module tx_data_buff (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       data_write,
    input  logic       consume,
    output logic [7:0] buf_data,
    output logic       buffer_full,
    output logic       write_error
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            buf_data    <= '0;
            buffer_full <= 1'b0;
            write_error <= 1'b0;
        end else begin
            // A write seen while full is rejected even if the FSM empties
            // the buffer on this same edge.
            write_error <= data_write && buffer_full;
            if (data_write && !buffer_full) begin
                buf_data    <= tx_data;
                buffer_full <= 1'b1;
            end else if (consume) begin
                buffer_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tx_block.sv
// tx_block: UART 8N1 transmitter (start bit, 8 data bits LSB first, stop bit).
//   CLKS_PER_BIT - clock cycles per serial bit (2..255)
//   clk          - system clock
//   n_rst        - asynchronous active-low reset; aborts any frame in flight
//   tx_data      - byte to transmit, sampled with data_write
//   data_write   - single-cycle write strobe into the holding buffer
//   serial_out   - registered serial line, idle high
//   buffer_full  - holding buffer occupied; writes rejected while high
//   tx_busy      - frame in progress
//   write_error  - one-cycle pulse after a rejected write
module tx_block
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       data_write,
    output logic       serial_out,
    output logic       buffer_full,
    output logic       tx_busy,
    output logic       write_error
);

    localparam int unsigned     TW         = timer_width(CLKS_PER_BIT);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LAST_IDX   = 3'(DATA_BITS - 1);

    tx_state_t     state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic [7:0]    buf_data;
    logic          bit_done;
    logic          consume;

    assign bit_done = (timer == TIMER_LAST);
    assign tx_busy  = (state != IDLE);

    // The buffer is taken from IDLE, or on the last stop-bit cycle so that
    // a refilled buffer starts the next frame with no idle gap.
    assign consume = buffer_full &&
                     ((state == IDLE) || ((state == STOP) && bit_done));

    tx_data_buff u_data_buff (
        .clk         (clk),
        .n_rst       (n_rst),
        .tx_data     (tx_data),
        .data_write  (data_write),
        .consume     (consume),
        .buf_data    (buf_data),
        .buffer_full (buffer_full),
        .write_error (write_error)
    );

    // serial_out is loaded with the level of the state being entered, so
    // the line changes on the same edge as the state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            serial_out <= STOP_BIT;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (consume) begin
                        shift_reg  <= buf_data;
                        state      <= START;
                        serial_out <= START_BIT;
                    end else begin
                        serial_out <= STOP_BIT;
                    end
                end
                START: begin
                    if (bit_done) begin
                        timer      <= '0;
                        bit_idx    <= '0;
                        state      <= DATA;
                        serial_out <= shift_reg[0];
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (bit_idx == LAST_IDX) begin
                            state      <= STOP;
                            serial_out <= STOP_BIT;
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            serial_out <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (consume) begin
                            shift_reg  <= buf_data;
                            state      <= START;
                            serial_out <= START_BIT;
                        end else begin
                            state      <= IDLE;
                            serial_out <= STOP_BIT;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    timer      <= '0;
                    serial_out <= STOP_BIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_block.sv
module tb_tx_block;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] tx_data1, tx_data2;
    logic       data_write1, data_write2;
    logic       so1, full1, busy1, err1;
    logic       so2, full2, busy2, err2;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    int unsigned rst_count = 0;

    logic [7:0]  exp_q1[$];
    logic [7:0]  exp_q2[$];
    int unsigned start_q1[$];
    int unsigned start_q2[$];

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       push;
        logic [3:0] exp;   // {serial_out, tx_busy, buffer_full, write_error}
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge n_rst) rst_count++;

    tx_block dut1 (
        .clk         (clk),
        .n_rst       (n_rst),
        .tx_data     (tx_data1),
        .data_write  (data_write1),
        .serial_out  (so1),
        .buffer_full (full1),
        .tx_busy     (busy1),
        .write_error (err1)
    );

    tx_block #(.CLKS_PER_BIT(2)) dut2 (
        .clk         (clk),
        .n_rst       (n_rst),
        .tx_data     (tx_data2),
        .data_write  (data_write2),
        .serial_out  (so2),
        .buffer_full (full2),
        .tx_busy     (busy2),
        .write_error (err2)
    );

    function automatic logic line(input int sel);
        return (sel == 2) ? so2 : so1;
    endfunction

    function automatic logic [3:0] outs(input int sel);
        return (sel == 2) ? {so2, busy2, full2, err2} : {so1, busy1, full1, err1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic wr, input logic [7:0] d);
        if (sel == 2) begin
            data_write2 = wr;
            tx_data2    = d;
        end else begin
            data_write1 = wr;
            tx_data1    = d;
        end
    endtask

    task automatic push_exp(input int sel, input logic [7:0] d);
        if (sel == 2) exp_q2.push_back(d);
        else          exp_q1.push_back(d);
    endtask

    // Decodes frames on one line by sampling the middle of each bit and
    // pops the scoreboard; frames cut by a reset are dropped.
    task automatic monitor(input int sel, input int c);
        logic [7:0]  d;
        logic        sb, pb;
        int unsigned t0, r0;
        forever begin
            @(negedge clk);
            if (n_rst === 1'b1 && line(sel) === 1'b0) begin
                t0 = cyc;
                r0 = rst_count;
                repeat (c / 2) @(negedge clk);
                sb = line(sel);
                for (int k = 0; k < 8; k++) begin
                    repeat (c) @(negedge clk);
                    d[k] = line(sel);
                end
                repeat (c) @(negedge clk);
                pb = line(sel);
                if (r0 == rst_count && n_rst === 1'b1) begin
                    check($sformatf("start_bit_dut%0d", sel), 32'(sb), 32'd0);
                    check($sformatf("stop_bit_dut%0d", sel), 32'(pb), 32'd1);
                    if ((sel == 2 ? exp_q2.size() : exp_q1.size()) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame_dut%0d: got %0h expected none", sel, d);
                    end else if (sel == 2) begin
                        check("frame_data_dut2", 32'(d), 32'(exp_q2.pop_front()));
                        start_q2.push_back(t0);
                    end else begin
                        check("frame_data_dut1", 32'(d), 32'(exp_q1.pop_front()));
                        start_q1.push_back(t0);
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input int sel, input int budget, input string name);
        int n = 0;
        while ((sel == 2 ? exp_q2.size() : exp_q1.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(sel == 2 ? exp_q2.size() : exp_q1.size()), 32'd0);
    endtask

    // Writes one byte into an idle transmitter and checks the line cycle by cycle.
    task automatic send_and_trace(input int sel, input logic [7:0] d, input int c);
        logic [9:0] pat;
        logic [3:0] o;
        pat = {1'b1, d, 1'b0};
        drive(sel, 1'b1, d);
        push_exp(sel, d);
        @(negedge clk);
        drive(sel, 1'b0, 8'h00);
        check($sformatf("after_E0_dut%0d", sel), 32'(outs(sel)), 32'h0000_000A);
        @(negedge clk);
        o = outs(sel);
        check($sformatf("after_E1_dut%0d", sel), 32'(o[2:0]), 32'd4);
        for (int i = 0; i < 10 * c; i++) begin
            check($sformatf("line_dut%0d_cycle%0d", sel, i), 32'(line(sel)), 32'(pat[i / c]));
            @(negedge clk);
        end
        check($sformatf("frame_end_dut%0d", sel), 32'(outs(sel)), 32'h0000_0008);
    endtask

    initial monitor(1, 10);
    initial monitor(2, 2);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst = 1'b0;
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check("reset_dut1", 32'(outs(1)), 32'h8);
        check("reset_dut2", 32'(outs(2)), 32'h8);
        n_rst = 1'b1;

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check($sformatf("idle_dut1_%0d", i), 32'(outs(1)), 32'h8);
        end

        // 0xA5 at 10 clocks per bit
        send_and_trace(1, 8'hA5, 10);
        wait_drain(1, 50, "drain_a5");

        // Back-to-back: second byte written while the first is in DATA
        repeat (5) @(negedge clk);
        start_q1.delete();
        drive(1, 1'b1, 8'h3C);
        push_exp(1, 8'h3C);
        @(negedge clk);
        drive(1, 1'b0, 8'h00);
        repeat (30) @(negedge clk);
        drive(1, 1'b1, 8'hC3);
        push_exp(1, 8'hC3);
        @(negedge clk);
        drive(1, 1'b0, 8'h00);
        check("b2b_no_error", 32'(err1), 32'd0);
        wait_drain(1, 400, "drain_b2b");
        check("b2b_frames", 32'(start_q1.size()), 32'd2);
        if (start_q1.size() == 2)
            check("b2b_spacing", start_q1[1] - start_q1[0], 32'd100);
        repeat (10) @(negedge clk);
        check("b2b_idle", 32'(outs(1)), 32'h8);

        // Table: accepted writes, a rejected write and write_error pulses
        vecs[0] = '{1'b1, 8'h11, 1'b1, 4'b1010};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 4'b0100};
        vecs[2] = '{1'b1, 8'h22, 1'b1, 4'b0110};
        vecs[3] = '{1'b1, 8'h33, 1'b0, 4'b0111};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 4'b0110};
        vecs[5] = '{1'b1, 8'h44, 1'b0, 4'b0111};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 4'b0110};
        for (int i = 0; i < 7; i++) begin
            drive(1, vecs[i].wr, vecs[i].data);
            if (vecs[i].push) push_exp(1, vecs[i].data);
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(outs(1)), 32'(vecs[i].exp));
        end
        drive(1, 1'b0, 8'h00);
        wait_drain(1, 400, "drain_table");
        repeat (150) @(negedge clk);
        check("table_idle", 32'(outs(1)), 32'h8);

        // Reset during data bit 4 of 0xFF with another byte buffered
        drive(1, 1'b1, 8'hFF);
        @(negedge clk);
        drive(1, 1'b0, 8'h00);
        @(negedge clk);
        repeat (20) @(negedge clk);
        drive(1, 1'b1, 8'h5A);
        @(negedge clk);
        drive(1, 1'b0, 8'h00);
        repeat (33) @(negedge clk);
        check("pre_reset", 32'(outs(1)), 32'hE);
        #1 n_rst = 1'b0;
        #1 check("mid_frame_reset", 32'(outs(1)), 32'h8);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_%0d", i), 32'(outs(1)), 32'h8);
        end

        // 0xA5 at 2 clocks per bit
        send_and_trace(2, 8'hA5, 2);
        wait_drain(2, 20, "drain_fast");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
